// File: rtl/sync_down_counter_pkg.sv
// Shared types for the loadable down counter: per-edge operation selection.
package sync_down_counter_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_DEC,
        OP_WRAP,
        OP_RELOAD
    } op_e;

    // Resolve load > en priority and the at-zero behaviour into one operation.
    function automatic op_e sel_op(
        input logic load,
        input logic en,
        input logic is_zero,
        input logic auto_reload
    );
        op_e op;
        if (load)                      op = OP_LOAD;
        else if (!en)                  op = OP_HOLD;
        else if (!is_zero)             op = OP_DEC;
        else if (auto_reload)          op = OP_RELOAD;
        else                           op = OP_WRAP;
        return op;
    endfunction

endpackage

// File: rtl/sync_down_counter_tff_sr.sv
// Toggle flip-flop with synchronous active-high reset to INIT.
module tff_sr #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (t) q_d = ~q_q;
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= INIT;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter on toggle flops with a borrow chain, optional auto-reload,
// and registered terminal-count / wrap pulses.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] t_dec;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q;
    logic             tc_d;
    logic             wrap_q;
    logic             wrap_d;
    op_e              op;

    assign zero = (q_bits == '0);

    // Borrow chain: bit i toggles when every lower bit is zero.
    always_comb begin
        t_dec    = '0;
        t_dec[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            t_dec[i] = t_dec[i-1] & ~q_bits[i-1];
        end
    end

    always_comb begin
        op       = sel_op(load, en, zero, auto_reload);
        q_next   = q_bits;
        tc_d     = 1'b0;
        wrap_d   = 1'b0;
        reload_d = reload_q;
        case (op)
            OP_LOAD: begin
                q_next   = load_val;
                reload_d = load_val;
            end
            OP_DEC: begin
                q_next = q_bits ^ t_dec;
                tc_d   = (q_bits == WIDTH'(1));
            end
            OP_WRAP: begin
                q_next = q_bits ^ t_dec;
                wrap_d = 1'b1;
            end
            OP_RELOAD: begin
                q_next = reload_q;
                wrap_d = 1'b1;
            end
            default: begin
                q_next = q_bits;
            end
        endcase
        toggle = q_next ^ q_bits;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_sr #(
            .INIT (1'b0)
        ) u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (toggle[i]),
            .q     (q_bits[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '1;
            tc_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            reload_q <= reload_d;
            tc_q     <= tc_d;
            wrap_q   <= wrap_d;
        end
    end

    assign q    = q_bits;
    assign tc   = tc_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: directed scenarios then random traffic.
module tb_sync_down_counter;

    localparam int unsigned WIDTH = 4;
    localparam int          MOD   = 1 << WIDTH;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             zero;
        logic             tc;
        logic             wrap;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             wrap;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    int   m_cnt;
    int   m_rel;

    sync_down_counter #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .q           (q),
        .zero        (zero),
        .tc          (tc),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus; the model predicts the state after the next rising edge.
    task automatic step(input logic r, input logic l, input int lv,
                        input logic e, input logic ar);
        exp_t x;
        @(negedge clk);
        reset       = r;
        load        = l;
        load_val    = WIDTH'(lv);
        en          = e;
        auto_reload = ar;
        x.tc   = 1'b0;
        x.wrap = 1'b0;
        if (r) begin
            m_cnt = 0;
            m_rel = MOD - 1;
        end else if (l) begin
            m_cnt = lv % MOD;
            m_rel = lv % MOD;
        end else if (e) begin
            if (m_cnt != 0) begin
                x.tc  = (m_cnt == 1);
                m_cnt = m_cnt - 1;
            end else begin
                x.wrap = 1'b1;
                m_cnt  = ar ? m_rel : MOD - 1;
            end
        end
        x.q    = WIDTH'(m_cnt);
        x.zero = (m_cnt == 0);
        exp_q.push_back(x);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents a new state every cycle; pop and compare after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (q !== x.q) begin
                    miscompares++;
                    $display("FAIL q at %0t: got %0d, expected %0d", $time, q, x.q);
                end
                check_bit("zero", zero, x.zero);
                check_bit("tc", tc, x.tc);
                check_bit("wrap", wrap, x.wrap);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_cnt       = 0;
        m_rel       = MOD - 1;
        reset       = 1'b0;
        en          = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        auto_reload = 1'b0;

        // Reset dominates load and en; then count from 0 wraps to all-ones.
        step(1, 1, 7, 1, 0);
        step(1, 1, 7, 1, 0);
        step(0, 0, 0, 1, 0);

        // Load 5 and count through terminal count into the wrap.
        step(0, 1, 5, 0, 0);
        repeat (6) step(0, 0, 0, 1, 0);

        // Periodic reload of 3.
        step(0, 1, 3, 0, 1);
        repeat (12) step(0, 0, 0, 1, 1);

        // Load beats an in-flight decrement, then hold with en low.
        step(0, 1, 6, 0, 0);
        step(0, 1, 9, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        // Reload value 0: stuck at zero, wrap every cycle, never tc.
        step(0, 1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 1, 1);

        // Reset mid-count restores the all-ones reload value.
        step(0, 1, 4, 0, 1);
        repeat (2) step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, MOD - 1)),
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
